// File: rtl/state_dumper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : state_dumper_pkg
//  Purpose  : Shared constants for the post-run state dumper: output kind
//             codes, FSM state encodings and the out_index width.
//  Contents : DUMP_KIND_REG / DUMP_KIND_MEM / DUMP_KIND_CSUM, DUMP_INDEX_W,
//             dump_state_t, max_u() helper.
//  Options  : STATE_DUMPER_CHECKSUM_EN adds the CSUM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package state_dumper_pkg;

  localparam int DUMP_INDEX_W = 16;

  localparam logic [1:0] DUMP_KIND_REG  = 2'b00;
  localparam logic [1:0] DUMP_KIND_MEM  = 2'b01;
  localparam logic [1:0] DUMP_KIND_CSUM = 2'b10;

  // Encodings are fixed so a debug probe can decode the state directly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REGS  = 3'd1,
    ST_MEM   = 3'd2,
`ifdef STATE_DUMPER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } dump_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/state_dumper_output_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dump_output_stage
//  Purpose  : Single-entry valid/ready output register for the state dumper.
//             A load captures a word and raises o_valid; an accept without a
//             new load drops o_valid; otherwise the entry holds.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_load          - capture i_data/i_kind/i_index this edge
//             i_ready         - consumer accepts the held word this cycle
//             o_valid/o_data/o_kind/o_index - registered output word
//             o_can_load      - entry is empty or being drained this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module dump_output_stage
  import state_dumper_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_ready,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [1:0]              i_kind,
  input  logic [DUMP_INDEX_W-1:0] i_index,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  output logic [1:0]              o_kind,
  output logic [DUMP_INDEX_W-1:0] o_index,
  output logic                    o_can_load
);

  assign o_can_load = !o_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_kind  <= '0;
      o_index <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_kind  <= i_kind;
      o_index <= i_index;
    end else if (o_valid && i_ready) begin
      // Payload is left in place after the final accept; only valid drops.
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/state_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : state_dumper
//  Purpose  : Post-run state readback for the MIPS CPU. On start it walks the
//             register file then the data memory through spare read ports
//             and streams every word out over a valid/ready interface.
//  Ports    : clock, reset           - clock, synchronous active-high reset
//             start                  - begin dump (honoured in IDLE/DONE)
//             busy, done             - dump in progress / dump complete
//             reg_read_address/data  - register file read port
//             mem_read_address/data  - data memory read port
//             out_valid/out_ready    - output handshake
//             out_data/kind/index    - dumped word, its kind and index
//  Options  : STATE_DUMPER_CHECKSUM_EN appends an XOR checksum word.
//  Revision : 1.0 - initial release
// ============================================================================
module state_dumper
  import state_dumper_pkg::*;
#(
  parameter int N_REGISTERS   = 32,
  parameter int DATA_MEM_SIZE = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(N_REGISTERS)-1:0]   reg_read_address,
  input  logic [31:0]                      reg_read_data,
  output logic [$clog2(DATA_MEM_SIZE)-1:0] mem_read_address,
  input  logic [31:0]                      mem_read_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_data,
  output logic [1:0]                       out_kind,
  output logic [DUMP_INDEX_W-1:0]          out_index
);

  localparam int c_reg_aw = $clog2(N_REGISTERS);
  localparam int c_mem_aw = $clog2(DATA_MEM_SIZE);
  localparam int c_cnt_w  = int'(max_u(c_reg_aw, c_mem_aw));

  localparam logic [c_cnt_w-1:0] c_reg_last = c_cnt_w'(N_REGISTERS - 1);
  localparam logic [c_cnt_w-1:0] c_mem_last = c_cnt_w'(DATA_MEM_SIZE - 1);

  dump_state_t          r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
`ifdef STATE_DUMPER_CHECKSUM_EN
  logic [31:0]          r_acc;
`endif

  logic                    w_can_load;
  logic                    w_load;
  logic [31:0]             w_word;
  logic [1:0]              w_kind;
  logic [DUMP_INDEX_W-1:0] w_index;

  // Both read ports follow the walk counter so the combinational read data
  // is ready to be captured in the same cycle.
  assign reg_read_address = r_cnt[c_reg_aw-1:0];
  assign mem_read_address = r_cnt[c_mem_aw-1:0];

  assign busy = r_busy;
  assign done = r_done;

  // Word selection for the section currently being walked.
  always_comb begin
    w_word  = reg_read_data;
    w_kind  = DUMP_KIND_REG;
    w_index = DUMP_INDEX_W'(r_cnt);
    w_load  = 1'b0;
    case (r_state)
      ST_REGS: begin
        w_load = w_can_load;
      end
      ST_MEM: begin
        w_word = mem_read_data;
        w_kind = DUMP_KIND_MEM;
        w_load = w_can_load;
      end
`ifdef STATE_DUMPER_CHECKSUM_EN
      ST_CSUM: begin
        w_word  = r_acc;
        w_kind  = DUMP_KIND_CSUM;
        w_index = '0;
        w_load  = w_can_load;
      end
`endif
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef STATE_DUMPER_CHECKSUM_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_REGS;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef STATE_DUMPER_CHECKSUM_EN
            r_acc   <= '0;
`endif
          end
        end
        ST_REGS: begin
          if (w_load) begin
`ifdef STATE_DUMPER_CHECKSUM_EN
            r_acc <= r_acc ^ w_word;
`endif
            if (r_cnt == c_reg_last) begin
              r_state <= ST_MEM;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_MEM: begin
          if (w_load) begin
`ifdef STATE_DUMPER_CHECKSUM_EN
            r_acc <= r_acc ^ w_word;
`endif
            if (r_cnt == c_mem_last) begin
`ifdef STATE_DUMPER_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_DRAIN;
`endif
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`ifdef STATE_DUMPER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_load) begin
            r_state <= ST_DRAIN;
          end
        end
`endif
        ST_DRAIN: begin
          // The last word leaves the output stage on this handshake.
          if (out_valid && out_ready) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  dump_output_stage #(
    .DATA_W (32)
  ) u_out (
    .clk        (clock),
    .rst        (reset),
    .i_load     (w_load),
    .i_ready    (out_ready),
    .i_data     (w_word),
    .i_kind     (w_kind),
    .i_index    (w_index),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_kind     (out_kind),
    .o_index    (out_index),
    .o_can_load (w_can_load)
  );

endmodule
`default_nettype wire

// File: tb/tb_state_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_state_dumper
//  Purpose  : Directed self-checking bench for state_dumper. Models the
//             register file and data memory as arrays with combinational
//             reads and checks every dumped word against the preload.
//  Options  : STATE_DUMPER_CHECKSUM_EN enables the checksum scenario and the
//             extra trailing word in every dump.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_state_dumper;

`ifdef STATE_DUMPER_CHECKSUM_EN
  localparam int TOTAL = 97;
`else
  localparam int TOTAL = 96;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  reg_read_address;
  logic [31:0] reg_read_data;
  logic [5:0]  mem_read_address;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_kind;
  logic [15:0] out_index;

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clock = ~clock;

  assign reg_read_data = regs[reg_read_address];
  assign mem_read_data = mem[mem_read_address];

  state_dumper #(
    .N_REGISTERS   (32),
    .DATA_MEM_SIZE (64)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .reg_read_address (reg_read_address),
    .reg_read_data    (reg_read_data),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_kind         (out_kind),
    .out_index        (out_index)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {kind, index, data} of word k, derived from the preload arrays.
  function automatic logic [49:0] exp_word(input int k);
    logic [31:0] x;
    if (k < 32) return {2'b00, 16'(k), regs[k]};
    if (k < 96) return {2'b01, 16'(k - 32), mem[k - 32]};
    x = '0;
    for (int i = 0; i < 32; i++) x ^= regs[i];
    for (int i = 0; i < 64; i++) x ^= mem[i];
    return {2'b10, 16'h0000, x};
  endfunction

  function automatic logic [49:0] obs_word();
    return {out_kind, out_index, out_data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0.
  // start_at >= 0 pulses start once when that many words have been accepted.
  task automatic dump(input int mode, input int start_at, input int total,
                      input bit check_end, output int cycles);
    int          got;
    int          c;
    bit          fired;
    logic        held;
    logic [49:0] snap;
    got   = 0;
    c     = 0;
    fired = 1'b0;
    while (got < total && c < 2000) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (!fired && start_at >= 0 && got == start_at) begin
        start = 1'b1;
        fired = 1'b1;
      end
      held = out_valid && !out_ready;
      snap = obs_word();
      if (out_valid && out_ready) begin
        chk($sformatf("word%0d", got), 64'(obs_word()), 64'(exp_word(got)));
        if (got == total - 1 && check_end) chk("done_before_last", 64'(done), 64'd0);
        got++;
      end
      tick();
      c++;
      start = 1'b0;
      if (held) chk($sformatf("hold_at_word%0d", got), 64'(obs_word()), 64'(snap));
    end
    chk("word_count", 64'(got), 64'(total));
    if (check_end) chk("end_done_busy_valid", 64'({done, busy, out_valid}), 64'b100);
    cycles = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    for (int i = 0; i < 64; i++) mem[i] = 32'(100 + i);
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_busy_done_valid", 64'({busy, done, out_valid}), 64'd0);
    chk("reset_out_word", 64'(obs_word()), 64'd0);
    chk("reset_addresses", 64'({reg_read_address, mem_read_address}), 64'd0);
    reset = 1'b0;
    tick();

    // Full-rate dump: first word two edges after start is raised, no bubbles.
    pulse_start();
    chk("start_busy_novalid", 64'({busy, out_valid}), 64'b10);
    dump(0, -1, TOTAL, 1'b1, cyc);
    chk("no_bubbles", 64'(cyc), 64'(TOTAL + 1));

    // Alternating ready: same sequence, stable while stalled.
    pulse_start();
    dump(1, -1, TOTAL, 1'b1, cyc);

    // Long stall on the first word.
    out_ready = 1'b0;
    pulse_start();
    tick();
    chk("stall_first_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_cycle%0d", i), 64'({out_valid, out_data, out_index}), {15'd0, 1'b1, 48'd0});
    end
    dump(0, -1, TOTAL, 1'b1, cyc);

    // Reset in the middle of a dump.
    pulse_start();
    dump(0, -1, 40, 1'b0, cyc);
    reset = 1'b1;
    tick();
    chk("midreset_busy_done_valid", 64'({busy, done, out_valid}), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("midreset_quiet", 64'({busy, done, out_valid}), 64'd0);
    pulse_start();
    dump(0, -1, TOTAL, 1'b1, cyc);

    // Start while busy is ignored; start in DONE restarts.
    pulse_start();
    dump(0, 20, TOTAL, 1'b1, cyc);
    chk("ignored_start_no_bubbles", 64'(cyc), 64'(TOTAL + 1));
    tick();
    tick();
    tick();
    chk("done_stays_quiet", 64'({done, busy, out_valid}), 64'b100);
    pulse_start();
    chk("restart_from_done", 64'({done, busy}), 64'b01);
    dump(0, -1, TOTAL, 1'b1, cyc);

`ifdef STATE_DUMPER_CHECKSUM_EN
    // Checksum of a single non-zero memory word.
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    pulse_start();
    dump(0, -1, 97, 1'b1, cyc);
    chk("checksum_word", 64'(obs_word()), 64'({2'b10, 16'h0000, 32'hDEADBEEF}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
